elev_scheduler: RTL

//  Request scheduler and motion sequencer for the elevator car.
//  - Latches hall and car floor requests into a pending set.
//  - Serves requests in SCAN order: keep the current direction while requests remain ahead, then reverse.
//  - Drives the floor select, door and motion outputs of the car datapath.
//  - Sits between the floor-button inputs and the elevator control datapath.

---
 rtl/elev_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/elev_scheduler.sv
// ---------------------------------------------------------------------------
// elev_scheduler
//   Request scheduler and motion sequencer for the elevator car. Hall and car
//   button requests are latched into a pending set and served in SCAN order:
//   the car keeps its direction while requests remain ahead of it, then turns
//   around. The floor select, door and motion outputs are all registered, so
//   no input reaches an output combinationally.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   hall_req   hall button pulses/levels, one bit per floor
//   car_req    in-car button pulses/levels, one bit per floor
//   floor_sel  current car floor (0 = bottom)
//   door       1 = door open
//   moving     1 = car travelling between floors
//   dir_up     current/last travel direction, 1 = up
//   pending    outstanding request set
// ---------------------------------------------------------------------------
module elev_scheduler #(
   parameter int NUM_FLOORS  = 4,
   parameter int DOOR_CYCLES = 3,
   parameter int MOVE_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_FLOORS-1:0]         hall_req,
   input  logic [NUM_FLOORS-1:0]         car_req,
   output logic [$clog2(NUM_FLOORS)-1:0] floor_sel,
   output logic                          door,
   output logic                          moving,
   output logic                          dir_up,
   output logic [NUM_FLOORS-1:0]         pending
);

   localparam int FW  = $clog2(NUM_FLOORS);
   localparam int DTW = $clog2(DOOR_CYCLES + 1);
   localparam int MTW = $clog2(MOVE_CYCLES + 1);
   localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      OPEN
   } stateT;

   stateT                 state, stateNext;
   logic [DTW-1:0]        doorTmr, doorTmrNext;
   logic [MTW-1:0]        moveTmr, moveTmrNext;
   logic [FW-1:0]         floorNext, stepFloor;
   logic                  dirNext;
   logic [NUM_FLOORS-1:0] pendingNext, reqIn, clrMask;
   logic                  hereReq, anyAbove, anyBelow, aheadReq;

   assign reqIn    = hall_req | car_req;
   assign hereReq  = pending[floor_sel];
   assign aheadReq = dir_up ? anyAbove : anyBelow;

   // Scheduling decisions look only at the registered pending set, so a new
   // request is captured on one edge and acted on from the next edge onward.
   // The step target saturates at the end floors so floor_sel never wraps.
   always_comb begin
      anyAbove  = 1'b0;
      anyBelow  = 1'b0;
      stepFloor = floor_sel;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (i > int'(floor_sel))) anyAbove = 1'b1;
         if (pending[i] && (i < int'(floor_sel))) anyBelow = 1'b1;
      end
      if (dir_up && (floor_sel != TOP_FLOOR)) begin
         stepFloor = floor_sel + FW'(1);
      end else if (!dir_up && (floor_sel != '0)) begin
         stepFloor = floor_sel - FW'(1);
      end
   end

   // State register plus the registered outputs and timers. door and moving
   // are taken from the next state so they change on the same edge as it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         floor_sel <= '0;
         door      <= 1'b0;
         moving    <= 1'b0;
         dir_up    <= 1'b1;
         pending   <= '0;
         doorTmr   <= '0;
         moveTmr   <= '0;
      end else begin
         state     <= stateNext;
         floor_sel <= floorNext;
         door      <= (stateNext == OPEN);
         moving    <= (stateNext == MOVE);
         dir_up    <= dirNext;
         pending   <= pendingNext;
         doorTmr   <= doorTmrNext;
         moveTmr   <= moveTmrNext;
      end
   end

   // Next-state logic. MOVE is only entered when a request lies strictly
   // above or below the car, since a request at the current floor wins.
   // A request at the open floor keeps the door open even on its last cycle.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (hereReq) begin
               stateNext = OPEN;
            end else if (anyAbove || anyBelow) begin
               stateNext = MOVE;
            end
         end
         MOVE: begin
            if ((moveTmr == MTW'(1)) && pending[stepFloor]) begin
               stateNext = OPEN;
            end
         end
         OPEN: begin
            if (!reqIn[floor_sel] && (doorTmr == DTW'(1))) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Next values of floor, direction, timers and the pending set. The
   // direction flips only when nothing lies ahead, and is pinned to the only
   // legal direction at the end floors whenever the car leaves IDLE. The
   // served floor is cleared from pending on entry to OPEN and throughout it,
   // which also absorbs repeat presses of that floor's buttons.
   always_comb begin
      floorNext   = floor_sel;
      dirNext     = dir_up;
      doorTmrNext = doorTmr;
      moveTmrNext = moveTmr;
      case (state)
         IDLE: begin
            if (hereReq) begin
               doorTmrNext = DTW'(DOOR_CYCLES);
            end else if (anyAbove || anyBelow) begin
               moveTmrNext = MTW'(MOVE_CYCLES);
               if (!aheadReq) dirNext = ~dir_up;
            end
            if (stateNext != IDLE) begin
               if (floor_sel == TOP_FLOOR) begin
                  dirNext = 1'b0;
               end else if (floor_sel == '0) begin
                  dirNext = 1'b1;
               end
            end
         end
         MOVE: begin
            if (moveTmr == MTW'(1)) begin
               floorNext = stepFloor;
               if (pending[stepFloor]) begin
                  doorTmrNext = DTW'(DOOR_CYCLES);
                  moveTmrNext = '0;
               end else begin
                  moveTmrNext = MTW'(MOVE_CYCLES);
               end
            end else begin
               moveTmrNext = moveTmr - MTW'(1);
            end
         end
         OPEN: begin
            if (reqIn[floor_sel]) begin
               doorTmrNext = DTW'(DOOR_CYCLES);
            end else if (doorTmr == DTW'(1)) begin
               doorTmrNext = '0;
            end else begin
               doorTmrNext = doorTmr - DTW'(1);
            end
         end
         default: ;
      endcase

      if ((state == OPEN) || (stateNext == OPEN)) begin
         clrMask = NUM_FLOORS'(1) << floorNext;
      end else begin
         clrMask = '0;
      end
      pendingNext = (pending | reqIn) & ~clrMask;
   end

endmodule
